token_multiplier: RTL and testbench

//  Serial token stream multiplier: each '1' token on a is re-emitted FACTOR

---
 rtl/token_multiplier.sv | 102 ++++++++++
 tb/tb_token_multiplier.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/token_multiplier.sv
// Serial token multiplier: each '1' on a_i is re-emitted factor_i times on b_o,
// with a saturating backlog counter, run-length guard and sticky overflow.
module token_multiplier #(
  parameter int FACTOR_W  = 3,
  parameter int CNT_W     = 8,
  parameter int RUN_LIMIT = 200
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                a_i,
  input  logic [FACTOR_W-1:0] factor_i,
  input  logic                out_ready_i,
  input  logic                clr_i,
  output logic                b_o,
  output logic [CNT_W-1:0]    pending_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic [1:0]          ovf_cause_o
);

  // Run counter must be able to hold RUN_LIMIT+1, the first illegal length.
  localparam int              RUN_W     = $clog2(RUN_LIMIT + 2);
  localparam logic [RUN_W-1:0] RUN_LIM_V = RUN_W'(RUN_LIMIT);
  localparam logic [RUN_W-1:0] RUN_SAT_V = RUN_W'(RUN_LIMIT + 1);
  localparam logic [CNT_W:0]   CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

  function automatic logic [CNT_W-1:0] sat_backlog(input logic [CNT_W:0] v);
    return (v > CNT_MAX) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction

  function automatic logic [RUN_W-1:0] sat_run_inc(input logic [RUN_W-1:0] r);
    return (r == RUN_SAT_V) ? r : r + 1'b1;
  endfunction

  logic             b_q, b_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       cause_q, cause_d;

  logic [CNT_W:0]   credit_w;
  logic [CNT_W:0]   total_w;
  logic [CNT_W:0]   next_w;
  logic             emit_w;
  logic             backlog_ovf_w;
  logic             run_ovf_w;

  // Arithmetic runs one bit wider than the counter so saturation is detectable.
  assign credit_w      = a_i ? (CNT_W+1)'(factor_i) : '0;
  assign total_w       = {1'b0, pending_q} + credit_w;
  assign emit_w        = out_ready_i && (total_w != '0);
  assign next_w        = total_w - {{CNT_W{1'b0}}, emit_w};
  assign backlog_ovf_w = next_w > CNT_MAX;
  assign run_ovf_w     = a_i && (run_q == RUN_LIM_V);

  always_comb begin
    b_d       = b_q;
    pending_d = pending_q;
    run_d     = run_q;
    ovf_d     = ovf_q;
    cause_d   = cause_q;
    if (clr_i) begin
      b_d       = 1'b0;
      pending_d = '0;
      run_d     = '0;
      ovf_d     = 1'b0;
      cause_d   = 2'b00;
    end else if (!ovf_q) begin
      b_d       = emit_w;
      pending_d = sat_backlog(next_w);
      run_d     = a_i ? sat_run_inc(run_q) : '0;
      ovf_d     = backlog_ovf_w | run_ovf_w;
      cause_d   = {backlog_ovf_w, run_ovf_w};
    end else begin
      // Overflowed: everything frozen except the output, which goes quiet.
      b_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_q       <= 1'b0;
      pending_q <= '0;
      run_q     <= '0;
      ovf_q     <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      b_q       <= b_d;
      pending_q <= pending_d;
      run_q     <= run_d;
      ovf_q     <= ovf_d;
      cause_q   <= cause_d;
    end
  end

  assign b_o         = b_q;
  assign pending_o   = pending_q;
  assign busy_o      = |pending_q;
  assign overflow_o  = ovf_q;
  assign ovf_cause_o = cause_q;

endmodule

// File: tb/tb_token_multiplier.sv
// Directed bench for token_multiplier: a default instance plus a CNT_W=4
// instance sharing the same inputs for backlog saturation scenarios.
module tb_token_multiplier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic [2:0] factor;
  logic       out_ready;
  logic       clr;

  logic       b, busy, overflow;
  logic [7:0] pending;
  logic [1:0] cause;
  logic       b_s, busy_s, overflow_s;
  logic [3:0] pending_s;
  logic [1:0] cause_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  token_multiplier #(.FACTOR_W(3), .CNT_W(8), .RUN_LIMIT(200)) dut (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a), .factor_i(factor),
    .out_ready_i(out_ready), .clr_i(clr), .b_o(b), .pending_o(pending),
    .busy_o(busy), .overflow_o(overflow), .ovf_cause_o(cause)
  );

  token_multiplier #(.FACTOR_W(3), .CNT_W(4), .RUN_LIMIT(200)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a), .factor_i(factor),
    .out_ready_i(out_ready), .clr_i(clr), .b_o(b_s), .pending_o(pending_s),
    .busy_o(busy_s), .overflow_o(overflow_s), .ovf_cause_o(cause_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL reset_b got %b exp 0", b); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b exp 00", cause); end
    checks++; if (pending_s !== 4'd0) begin errors++; $display("FAIL reset_pending_s got %0d exp 0", pending_s); end
  endtask

  task automatic test_stream();
    logic [10:0] a_vec;
    logic [10:0] b_exp;
    a_vec = 11'b10010011000;
    b_exp = 11'b11011011110;
    factor = 3'd2; out_ready = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      a = a_vec[i];
      tick();
      checks++; if (b !== b_exp[i]) begin errors++; $display("FAIL stream_b[%0d] got %b exp %b", 10 - i, b, b_exp[i]); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf[%0d] got %b exp 0", 10 - i, overflow); end
    end
    a = 1'b0;
  endtask

  task automatic test_factor3();
    logic [7:0] p_exp;
    factor = 3'd3; out_ready = 1'b1; a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      a = 1'b0;
      p_exp = 8'(2 - i);
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL f3_b[%0d] got %b exp 1", i, b); end
      checks++; if (pending !== p_exp) begin errors++; $display("FAIL f3_pending[%0d] got %0d exp %0d", i, pending, p_exp); end
      checks++; if (busy !== (i < 2)) begin errors++; $display("FAIL f3_busy[%0d] got %b exp %b", i, busy, (i < 2)); end
    end
    tick();
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL f3_b_after got %b exp 0", b); end
  endtask

  task automatic test_stall();
    logic [7:0] p_exp;
    factor = 3'd3; out_ready = 1'b0; a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      a = 1'b0;
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL stall_b[%0d] got %b exp 0", i, b); end
      checks++; if (pending !== 8'd3) begin errors++; $display("FAIL stall_pending[%0d] got %0d exp 3", i, pending); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      p_exp = 8'(2 - i);
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL drain_b[%0d] got %b exp 1", i, b); end
      checks++; if (pending !== p_exp) begin errors++; $display("FAIL drain_pending[%0d] got %0d exp %0d", i, pending, p_exp); end
    end
    tick();
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL drain_b_after got %b exp 0", b); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL drain_pending_after got %0d exp 0", pending); end
  endtask

  task automatic test_factor_zero();
    factor = 3'd0; out_ready = 1'b1; a = 1'b1;
    tick();
    a = 1'b0;
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL f0_b got %b exp 0", b); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL f0_pending got %0d exp 0", pending); end
  endtask

  task automatic test_run_limit();
    factor = 3'd1; out_ready = 1'b1; a = 1'b0;
    tick();
    a = 1'b1;
    repeat (200) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL run200_ovf got %b exp 0", overflow); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL run200_b got %b exp 1", b); end
    a = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL run200_gap_ovf got %b exp 0", overflow); end
    a = 1'b1;
    repeat (200) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL run201_pre_ovf got %b exp 0", overflow); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL run201_ovf got %b exp 1", overflow); end
    checks++; if (cause !== 2'b01) begin errors++; $display("FAIL run201_cause got %b exp 01", cause); end
    a = 1'b0;
    tick();
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL run201_b_quiet got %b exp 0", b); end
    factor = 3'd7; a = 1'b1;
    tick();
    a = 1'b0;
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL frozen_b got %b exp 0", b); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL frozen_pending got %0d exp 0", pending); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL frozen_ovf got %b exp 1", overflow); end
    checks++; if (cause !== 2'b01) begin errors++; $display("FAIL frozen_cause got %b exp 01", cause); end
  endtask

  task automatic test_clear();
    clr = 1'b1; a = 1'b1; factor = 3'd5; out_ready = 1'b0;
    tick();
    clr = 1'b0; a = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", overflow); end
    checks++; if (cause !== 2'b00) begin errors++; $display("FAIL clr_cause got %b exp 00", cause); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL clr_pending got %0d exp 0", pending); end
    tick();
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL clr_dropped_pending got %0d exp 0", pending); end
  endtask

  task automatic test_backlog();
    factor = 3'd5; out_ready = 1'b0; a = 1'b1;
    repeat (3) tick();
    a = 1'b0;
    checks++; if (pending_s !== 4'd15) begin errors++; $display("FAIL bl15_pending_s got %0d exp 15", pending_s); end
    checks++; if (overflow_s !== 1'b0) begin errors++; $display("FAIL bl15_ovf_s got %b exp 0", overflow_s); end
    clr = 1'b1;
    tick();
    clr = 1'b0; factor = 3'd7; a = 1'b1;
    tick();
    checks++; if (pending_s !== 4'd7) begin errors++; $display("FAIL bl_p1_s got %0d exp 7", pending_s); end
    tick();
    checks++; if (pending_s !== 4'd14) begin errors++; $display("FAIL bl_p2_s got %0d exp 14", pending_s); end
    tick();
    a = 1'b0;
    checks++; if (pending_s !== 4'd15) begin errors++; $display("FAIL bl_sat_pending_s got %0d exp 15", pending_s); end
    checks++; if (overflow_s !== 1'b1) begin errors++; $display("FAIL bl_sat_ovf_s got %b exp 1", overflow_s); end
    checks++; if (cause_s !== 2'b10) begin errors++; $display("FAIL bl_sat_cause_s got %b exp 10", cause_s); end
    checks++; if (pending !== 8'd21) begin errors++; $display("FAIL bl_wide_pending got %0d exp 21", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bl_wide_ovf got %b exp 0", overflow); end
    out_ready = 1'b1;
    tick();
    checks++; if (b_s !== 1'b0) begin errors++; $display("FAIL bl_frozen_b_s got %b exp 0", b_s); end
    checks++; if (pending_s !== 4'd15) begin errors++; $display("FAIL bl_frozen_pending_s got %0d exp 15", pending_s); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (pending_s !== 4'd0) begin errors++; $display("FAIL bl_clr_pending_s got %0d exp 0", pending_s); end
    checks++; if (overflow_s !== 1'b0) begin errors++; $display("FAIL bl_clr_ovf_s got %b exp 0", overflow_s); end
    checks++; if (cause_s !== 2'b00) begin errors++; $display("FAIL bl_clr_cause_s got %b exp 00", cause_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL bl_clr_busy_s got %b exp 0", busy_s); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL bl_clr_pending got %0d exp 0", pending); end
  endtask

  task automatic test_async_reset();
    factor = 3'd6; out_ready = 1'b1; a = 1'b1;
    tick();
    a = 1'b0;
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL ar_pre_b got %b exp 1", b); end
    checks++; if (pending !== 8'd5) begin errors++; $display("FAIL ar_pre_pending got %0d exp 5", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL ar_b got %b exp 0", b); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL ar_pending got %0d exp 0", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_ovf got %b exp 0", overflow); end
    #1;
    rst_n = 1'b1;
    factor = 3'd2; a = 1'b1;
    tick();
    a = 1'b0;
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL ar_resume_b got %b exp 1", b); end
    checks++; if (pending !== 8'd1) begin errors++; $display("FAIL ar_resume_pending got %0d exp 1", pending); end
    tick();
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL ar_resume_b2 got %b exp 1", b); end
    checks++; if (pending !== 8'd0) begin errors++; $display("FAIL ar_resume_pending2 got %0d exp 0", pending); end
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b0; factor = 3'd0; out_ready = 1'b0; clr = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_stream();
    test_factor3();
    test_stall();
    test_factor_zero();
    test_run_limit();
    test_clear();
    test_backlog();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
